// File: rtl/ysyx_25040111_mem_arbiter.sv
`default_nettype none
// ysyx_25040111_mem_arbiter: shares one memory channel between I-cache burst refills and LSU accesses.
// Revision 1.0
module ysyx_25040111_mem_arbiter #(
  parameter int PRIO_D = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_rstart,
  input  logic [31:0] i_raddr,
  input  logic [7:0]  i_rlen,
  output logic        i_rok,
  output logic [31:0] i_rdata,
  input  logic        d_start,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_ok,
  output logic [31:0] d_rdata,
  output logic        m_start,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  output logic [7:0]  m_rlen,
  input  logic        m_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_I_BUSY = 2'd1,
    S_I_GAP  = 2'd2,
    S_D_BUSY = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_i_pend;
  logic [31:0] r_i_addr_p;
  logic [7:0]  r_i_len_p;
  logic        r_d_pend;
  logic        r_d_wen_p;
  logic [31:0] r_d_addr_p;
  logic [31:0] r_d_wdata_p;
  logic [3:0]  r_d_wmask_p;

  logic [7:0]  r_cnt;
  logic [7:0]  r_burst_len;
  logic        r_last_d;

  logic        r_m_start;
  logic        r_m_wen;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_wmask;
  logic [7:0]  r_m_rlen;

  logic        w_i_req;
  logic        w_d_req;
  logic [31:0] w_i_addr;
  logic [7:0]  w_i_len;
  logic        w_d_wen;
  logic [31:0] w_d_addr;
  logic [31:0] w_d_wdata;
  logic [3:0]  w_d_wmask;

  logic        w_grant_i;
  logic        w_issue_i;
  logic        w_issue_d;
  logic        w_beat_next;
  logic        w_burst_end;
  logic        w_d_end;

  // A latched request is older than any live pulse, so its fields take precedence.
  assign w_i_req   = i_rstart | r_i_pend;
  assign w_d_req   = d_start | r_d_pend;
  assign w_i_addr  = r_i_pend ? r_i_addr_p  : i_raddr;
  assign w_i_len   = r_i_pend ? r_i_len_p   : i_rlen;
  assign w_d_wen   = r_d_pend ? r_d_wen_p   : d_wen;
  assign w_d_addr  = r_d_pend ? r_d_addr_p  : d_addr;
  assign w_d_wdata = r_d_pend ? r_d_wdata_p : d_wdata;
  assign w_d_wmask = r_d_pend ? r_d_wmask_p : d_wmask;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_issue_i   = 1'b0;
    w_issue_d   = 1'b0;
    w_beat_next = 1'b0;
    w_burst_end = 1'b0;
    w_d_end     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_d_req && (!w_i_req || (PRIO_D != 0) || !r_last_d)) begin
          w_issue_d   = 1'b1;
          w_state_nxt = S_D_BUSY;
        end else if (w_i_req) begin
          w_grant_i   = 1'b1;
          w_issue_i   = 1'b1;
          w_state_nxt = S_I_BUSY;
        end
      end
      S_I_BUSY: begin
        if (m_ok) begin
          if (r_cnt == r_burst_len) begin
            w_burst_end = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_beat_next = 1'b1;
            w_state_nxt = S_I_GAP;
          end
        end
      end
      S_I_GAP: begin
        // The burst keeps the channel; LSU requests here only become pending.
        if (w_i_req) begin
          w_issue_i   = 1'b1;
          w_state_nxt = S_I_BUSY;
        end
      end
      S_D_BUSY: begin
        if (m_ok) begin
          w_d_end     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_pend    <= 1'b0;
      r_i_addr_p  <= 32'd0;
      r_i_len_p   <= 8'd0;
      r_d_pend    <= 1'b0;
      r_d_wen_p   <= 1'b0;
      r_d_addr_p  <= 32'd0;
      r_d_wdata_p <= 32'd0;
      r_d_wmask_p <= 4'd0;
    end else begin
      if (w_issue_i) begin
        r_i_pend <= 1'b0;
      end else if (i_rstart && !r_i_pend) begin
        r_i_pend   <= 1'b1;
        r_i_addr_p <= i_raddr;
        r_i_len_p  <= i_rlen;
      end
      if (w_issue_d) begin
        r_d_pend <= 1'b0;
      end else if (d_start && !r_d_pend) begin
        r_d_pend    <= 1'b1;
        r_d_wen_p   <= d_wen;
        r_d_addr_p  <= d_addr;
        r_d_wdata_p <= d_wdata;
        r_d_wmask_p <= d_wmask;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= 8'd0;
      r_burst_len <= 8'd0;
      r_last_d    <= 1'b0;
    end else begin
      if (w_grant_i) begin
        r_cnt       <= 8'd0;
        r_burst_len <= w_i_len;
      end else if (w_beat_next) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_burst_end) begin
        r_last_d <= 1'b0;
      end else if (w_d_end) begin
        r_last_d <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_m_start <= 1'b0;
      r_m_wen   <= 1'b0;
      r_m_addr  <= 32'd0;
      r_m_wdata <= 32'd0;
      r_m_wmask <= 4'd0;
      r_m_rlen  <= 8'd0;
    end else begin
      r_m_start <= w_issue_i | w_issue_d;
      if (w_issue_i) begin
        r_m_wen   <= 1'b0;
        r_m_addr  <= w_i_addr;
        r_m_wdata <= 32'd0;
        r_m_wmask <= 4'd0;
        r_m_rlen  <= w_grant_i ? w_i_len : r_burst_len;
      end else if (w_issue_d) begin
        r_m_wen   <= w_d_wen;
        r_m_addr  <= w_d_addr;
        r_m_wdata <= w_d_wdata;
        r_m_wmask <= w_d_wmask;
        r_m_rlen  <= 8'd0;
      end
    end
  end

  assign m_start = r_m_start;
  assign m_wen   = r_m_wen;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_wmask = r_m_wmask;
  assign m_rlen  = r_m_rlen;

  // Responses go only to the current owner; m_ok in any other state is dropped.
  assign i_rok   = (r_state == S_I_BUSY) & m_ok;
  assign d_ok    = (r_state == S_D_BUSY) & m_ok;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
`default_nettype none
// tb_ysyx_25040111_mem_arbiter: scoreboard bench, expected requests/responses tagged with their cycle.
module tb_ysyx_25040111_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_rstart;
  logic [31:0] i_raddr;
  logic [7:0]  i_rlen;
  logic        i_rok;
  logic [31:0] i_rdata;
  logic        d_start;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_ok;
  logic [31:0] d_rdata;
  logic        m_start;
  logic        m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic [7:0]  m_rlen;
  logic        m_ok;
  logic [31:0] m_rdata;

  ysyx_25040111_mem_arbiter #(.PRIO_D(0)) dut (
    .clock(clock), .reset(reset),
    .i_rstart(i_rstart), .i_raddr(i_raddr), .i_rlen(i_rlen),
    .i_rok(i_rok), .i_rdata(i_rdata),
    .d_start(d_start), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_ok(d_ok), .d_rdata(d_rdata),
    .m_start(m_start), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_rlen(m_rlen), .m_ok(m_ok), .m_rdata(m_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [7:0]  rlen;
  } mreq_t;
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  mreq_t q_m[$];
  rsp_t  q_i[$];
  rsp_t  q_d[$];
  mreq_t em;
  rsp_t  er;

  task automatic push_m(input int c, input logic wen, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, input logic [7:0] rl);
    mreq_t t;
    t.cyc = c; t.wen = wen; t.addr = a; t.wdata = wd; t.wmask = wm; t.rlen = rl;
    q_m.push_back(t);
  endtask

  task automatic push_i(input int c, input logic [31:0] d);
    rsp_t t;
    t.cyc = c; t.data = d;
    q_i.push_back(t);
  endtask

  task automatic push_d(input int c, input logic [31:0] d);
    rsp_t t;
    t.cyc = c; t.data = d;
    q_d.push_back(t);
  endtask

  // Monitor: every DUT output event is matched against the head of its queue.
  always @(negedge clock) begin
    while (q_m.size() > 0 && q_m[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL m_start_missing: got none, required at cycle %0d addr %h", q_m[0].cyc, q_m[0].addr);
      void'(q_m.pop_front());
    end
    while (q_i.size() > 0 && q_i[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL i_rok_missing: got none, required at cycle %0d data %h", q_i[0].cyc, q_i[0].data);
      void'(q_i.pop_front());
    end
    while (q_d.size() > 0 && q_d[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL d_ok_missing: got none, required at cycle %0d data %h", q_d[0].cyc, q_d[0].data);
      void'(q_d.pop_front());
    end
    if (m_start === 1'b1) begin
      checks++;
      if (q_m.size() > 0 && q_m[0].cyc == cyc) begin
        em = q_m.pop_front();
        if ({m_wen, m_addr, m_wdata, m_wmask, m_rlen} !== {em.wen, em.addr, em.wdata, em.wmask, em.rlen}) begin
          errors++;
          $display("FAIL m_fields @%0d: got wen=%b addr=%h wdata=%h wmask=%h rlen=%0d, required wen=%b addr=%h wdata=%h wmask=%h rlen=%0d",
                   cyc, m_wen, m_addr, m_wdata, m_wmask, m_rlen, em.wen, em.addr, em.wdata, em.wmask, em.rlen);
        end
      end else begin
        errors++;
        $display("FAIL m_start_unexpected @%0d: got addr %h, required no request", cyc, m_addr);
      end
    end
    if (i_rok === 1'b1) begin
      checks++;
      if (q_i.size() > 0 && q_i[0].cyc == cyc) begin
        er = q_i.pop_front();
        if (i_rdata !== er.data) begin
          errors++;
          $display("FAIL i_rdata @%0d: got %h, required %h", cyc, i_rdata, er.data);
        end
      end else begin
        errors++;
        $display("FAIL i_rok_unexpected @%0d: got 1, required 0", cyc);
      end
    end
    if (d_ok === 1'b1) begin
      checks++;
      if (q_d.size() > 0 && q_d[0].cyc == cyc) begin
        er = q_d.pop_front();
        if (d_rdata !== er.data) begin
          errors++;
          $display("FAIL d_rdata @%0d: got %h, required %h", cyc, d_rdata, er.data);
        end
      end else begin
        errors++;
        $display("FAIL d_ok_unexpected @%0d: got 1, required 0", cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    i_rstart = 1'b0;
    d_start  = 1'b0;
    m_ok     = 1'b0;
  endtask

  task automatic set_i(input logic [31:0] a, input logic [7:0] len);
    i_rstart = 1'b1; i_raddr = a; i_rlen = len;
  endtask

  task automatic set_d(input logic wen, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    d_start = 1'b1; d_wen = wen; d_addr = a; d_wdata = wd; d_wmask = wm;
  endtask

  task automatic set_ok(input logic [31:0] d);
    m_ok = 1'b1; m_rdata = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_start"}, 32'(m_start), 32'd0);
    chk({tag, "_m_wen"},   32'(m_wen),   32'd0);
    chk({tag, "_m_addr"},  m_addr,       32'd0);
    chk({tag, "_m_wdata"}, m_wdata,      32'd0);
    chk({tag, "_m_wmask"}, 32'(m_wmask), 32'd0);
    chk({tag, "_m_rlen"},  32'(m_rlen),  32'd0);
    chk({tag, "_i_rok"},   32'(i_rok),   32'd0);
    chk({tag, "_d_ok"},    32'(d_ok),    32'd0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cycle();
    chk_reset_outputs(tag);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  int c0;

  initial begin
    reset = 1'b1; i_rstart = 1'b0; i_raddr = '0; i_rlen = '0;
    d_start = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    m_ok = 1'b0; m_rdata = '0;
    cycle();
    do_reset("rst0");

    // I burst alone: four beats, rlen=3, next beat requested from I_GAP.
    for (int b = 0; b < 4; b++) begin
      set_i(32'h8000_0010 + 32'(4 * b), 8'd3);
      push_m(cyc + 1, 1'b0, 32'h8000_0010 + 32'(4 * b), 32'd0, 4'd0, 8'd3);
      cycle();
      cycle();
      set_ok(32'hc0de_0000 + 32'(b));
      push_i(cyc, 32'hc0de_0000 + 32'(b));
      cycle();
    end

    // Stray m_ok in IDLE produces nothing.
    set_ok(32'hbad0_0001);
    cycle();
    cycle();

    // D write alone.
    set_d(1'b1, 32'ha000_03f8, 32'h0000_0041, 4'b0001);
    push_m(cyc + 1, 1'b1, 32'ha000_03f8, 32'h0000_0041, 4'b0001, 8'd0);
    cycle();
    cycle();
    set_ok(32'h1234_5678);
    push_d(cyc, 32'h1234_5678);
    cycle();

    // Tie after reset: D first, I 2 cycles after D's m_ok; then a D pulse
    // coincident with that m_ok ties with pending I and must lose.
    do_reset("rst1");
    c0 = cyc;
    set_i(32'h8000_1000, 8'd0);
    set_d(1'b0, 32'h0000_0010, 32'd0, 4'hf);
    push_m(c0 + 1, 1'b0, 32'h0000_0010, 32'd0, 4'hf, 8'd0);
    cycle();
    cycle();
    set_ok(32'haaaa_0001);
    push_d(c0 + 2, 32'haaaa_0001);
    set_d(1'b0, 32'h0000_0020, 32'hdead_beef, 4'hf);
    push_m(c0 + 4, 1'b0, 32'h8000_1000, 32'd0, 4'd0, 8'd0);
    cycle();
    cycle();
    cycle();
    set_ok(32'hbbbb_0001);
    push_i(c0 + 5, 32'hbbbb_0001);
    push_m(c0 + 7, 1'b0, 32'h0000_0020, 32'hdead_beef, 4'hf, 8'd0);
    cycle();
    cycle();
    cycle();
    set_ok(32'hcccc_0001);
    push_d(c0 + 8, 32'hcccc_0001);
    cycle();

    // D request during I_GAP of an rlen=3 burst, plus a stray m_ok in I_GAP.
    set_i(32'h8000_2000, 8'd3);
    push_m(cyc + 1, 1'b0, 32'h8000_2000, 32'd0, 4'd0, 8'd3);
    cycle();
    cycle();
    set_ok(32'h2222_0000);
    push_i(cyc, 32'h2222_0000);
    cycle();
    set_d(1'b1, 32'h0000_0030, 32'h0000_0055, 4'b0011);
    cycle();
    set_ok(32'hbad0_0002);
    cycle();
    for (int b = 1; b < 4; b++) begin
      set_i(32'h8000_2000 + 32'(4 * b), 8'd3);
      push_m(cyc + 1, 1'b0, 32'h8000_2000 + 32'(4 * b), 32'd0, 4'd0, 8'd3);
      cycle();
      cycle();
      set_ok(32'h2222_0000 + 32'(b));
      push_i(cyc, 32'h2222_0000 + 32'(b));
      if (b == 3) push_m(cyc + 2, 1'b1, 32'h0000_0030, 32'h0000_0055, 4'b0011, 8'd0);
      cycle();
    end
    cycle();
    cycle();
    set_ok(32'h3333_0000);
    push_d(cyc, 32'h3333_0000);
    cycle();

    // Reset during I_BUSY of beat 2 with a D request pending: nothing replays.
    set_i(32'h8000_3000, 8'd3);
    push_m(cyc + 1, 1'b0, 32'h8000_3000, 32'd0, 4'd0, 8'd3);
    cycle();
    cycle();
    set_ok(32'h4444_0000);
    push_i(cyc, 32'h4444_0000);
    cycle();
    set_i(32'h8000_3004, 8'd3);
    push_m(cyc + 1, 1'b0, 32'h8000_3004, 32'd0, 4'd0, 8'd3);
    cycle();
    set_d(1'b0, 32'h0000_0040, 32'd0, 4'd0);
    cycle();
    do_reset("rst_mid");
    set_ok(32'hbad0_0003);
    cycle();
    repeat (5) cycle();

    chk("q_m_drained", 32'(q_m.size()), 32'd0);
    chk("q_i_drained", 32'(q_i.size()), 32'd0);
    chk("q_d_drained", 32'(q_d.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_25040111_mem_arbiter.md
# ysyx_25040111_mem_arbiter

Two-port arbiter that shares the single downstream memory read/write channel between the instruction-cache refill port (multi-beat read bursts) and the LSU port (single-beat read or write). It sits between the I-cache/LSU and the bus bridge. It holds the grant for an entire I-cache burst, latches requests that arrive while the channel is busy, and routes responses back to the current owner only.

## Interface
- PRIO_D, default 0: 1 = fixed priority (LSU always wins ties); 0 = alternate ties, with the LSU winning the first tie after reset.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- i_rstart  in  1  one-cycle pulse; I-cache requests one beat
- i_raddr  in  32  beat address, valid with i_rstart
- i_rlen  in  8  burst beats minus 1, valid with the first i_rstart of a burst
- i_rok  out  1  beat data valid for the I-cache
- i_rdata  out  32  beat data
- d_start  in  1  one-cycle pulse; LSU access request
- d_wen  in  1  1 = write, 0 = read
- d_addr  in  32  access address
- d_wdata  in  32  write data
- d_wmask  in  4  byte strobes
- d_ok  out  1  access done; read data valid
- d_rdata  out  32  read data
- m_start  out  1  one-cycle pulse to the bridge
- m_wen, m_addr[32], m_wdata[32], m_wmask[4], m_rlen[8]  out  registered request fields
- m_ok  in  1  downstream beat/access done
- m_rdata  in  32  downstream read data

## Operation
- States:
  - IDLE
  - I_BUSY: I beat outstanding
  - I_GAP: burst granted, waiting for the next i_rstart
  - D_BUSY: LSU access outstanding
- Pending latches i_pend and d_pend:
  - A start pulse that is not consumed in the same cycle sets its pending latch and captures that request's fields.
  - A consumed request clears its latch.
  - A second pulse from a port that is already pending is dropped. Requesters are not allowed to do this.
- IDLE arbitration. The candidates are the live pulse or the pending latch of each port.
  - Only one port requesting: that port is granted.
  - Both requesting, PRIO_D=1: grant D.
  - Both requesting, PRIO_D=0: grant the port not granted last. The last-granted flag resets to I, so D wins the first tie.
- Grant I:
  - Load beat counter = 0 and latch burst_len = i_rlen.
  - Next cycle: m_start=1, m_wen=0, m_addr=i_raddr, m_rlen=burst_len. Go to I_BUSY.
- I_BUSY, when m_ok=1:
  - Drive i_rok=1 and i_rdata=m_rdata in the same cycle (combinational).
  - If counter == burst_len, go to IDLE and set last=I.
  - Otherwise increment the counter and go to I_GAP.
- I_GAP:
  - On i_rstart, issue m_start next cycle with the new i_raddr and go to I_BUSY.
  - A d_start in I_GAP only sets d_pend. The burst is never interrupted.
- Grant D:
  - Next cycle: m_start=1 with the latched d_* fields and m_rlen=0. Go to D_BUSY.
  - On m_ok: drive d_ok=1 and d_rdata=m_rdata in the same cycle, go to IDLE, set last=D.
- Response routing:
  - i_rok is asserted only in I_BUSY; d_ok only in D_BUSY.
  - m_ok in IDLE or I_GAP is ignored.
- Width rules:
  - Beat counter is 8 bits and compared for equality with burst_len; it never wraps past 255.
  - burst_len=0 is a single-beat burst: first m_ok returns to IDLE.

## Timing
- Reset values: m_start=0, m_wen=0, m_addr=0, m_wdata=0, m_wmask=0, m_rlen=0, i_rok=0, d_ok=0, i_rdata/d_rdata follow m_rdata (don't-care). State=IDLE, pending latches and counter cleared, last=I.
- Request to m_start latency:
  - Exactly 1 cycle from a start pulse (or pending latch) seen in IDLE.
  - 1 cycle from i_rstart in I_GAP.
  - A deferred request issues m_start 1 cycle after the state returns to IDLE. Example: m_ok ends the owner at cycle t, state is IDLE at t+1, m_start at t+2.
- m_start is high for exactly one cycle per beat/access. Fields are held stable until the next m_start.
- A start pulse coincident with m_ok that ends the current grant is latched as pending; it is not lost.
- Reset mid-operation: state returns to IDLE and all pending requests are discarded. Requesters also reset, so there is no replay.

## Test plan
- I burst alone: i_rstart, i_raddr=0x8000_0010, i_rlen=3.
  - m_start at +1 with m_addr=0x8000_0010, m_rlen=3.
  - Four m_ok pulses give four i_rok pulses with the matching data.
  - State is IDLE after the 4th beat; d_ok stays 0 throughout.
- D write alone: d_start, d_wen=1, d_addr=0xa000_03f8, d_wdata=0x41, d_wmask=4'b0001.
  - m_start at +1 with those fields and m_rlen=0.
  - m_ok gives d_ok=1 in the same cycle.
- Tie after reset (PRIO_D=0): i_rstart and d_start in the same cycle.
  - D is issued first.
  - I is issued 2 cycles after D's m_ok.
  - The next tie is granted to I.
- D request during I_GAP of an rlen=3 burst:
  - d_pend is set and no D m_start appears before the 4th I beat completes.
  - D's m_start follows 2 cycles after that beat's m_ok.
- Reset asserted in I_BUSY of beat 2:
  - All outputs return to reset values the next cycle.
  - A later stray m_ok produces no i_rok or d_ok.
- Stray m_ok in IDLE and in I_GAP: i_rok=0, d_ok=0, and the state is unchanged.
